uart_tx_arbiter: RTL and testbench

// - Shares one UART transmitter (wifi_uart TXD path) between two byte-stream requesters: s0 = HPS bridge, s1 = NIOS.
// - Message-locked round-robin: a grant is held for a whole message, so bytes from the two sources never interleave.
// - A message ends on the terminator byte, on MAX_MSG bytes, or after IDLE_TIMEOUT stall cycles.
// - Sits between the two command producers and the UART core inside tag_nios_system.

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter sharing one UART TX byte stream between two sources.
// A grant is held until the terminator byte, MAX_MSG bytes, or IDLE_TIMEOUT stalled cycles.
module uart_tx_arbiter #(
  parameter int unsigned       DATA_W       = 8,
  parameter logic [DATA_W-1:0] TERM         = 8'h0A,
  parameter int unsigned       MAX_MSG      = 256,
  parameter int unsigned       IDLE_TIMEOUT = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        grant,
  output logic              timeout
);

  localparam int unsigned BcW = $clog2(MAX_MSG + 1);
  localparam int unsigned IcW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [BcW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [IcW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic [1:0]        grant_q, grant_d;
  logic              timeout_q, timeout_d;

  logic              drain_ok;
  logic              xfer;
  logic              rel;
  logic [DATA_W-1:0] xfer_data;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    timeout_d  = 1'b0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    xfer       = 1'b0;
    xfer_data  = '0;
    rel        = 1'b0;
    drain_ok   = ~m_valid_q | m_ready;

    case (state_q)
      StIdle: begin
        // rr_q names the last served source; on contention the other one wins.
        if (s0_valid && (!s1_valid || rr_q)) begin
          state_d = StLock0;
        end else if (s1_valid) begin
          state_d = StLock1;
        end
      end
      StLock0: begin
        s0_ready  = drain_ok;
        xfer      = s0_valid & drain_ok;
        xfer_data = s0_data;
      end
      StLock1: begin
        s1_ready  = drain_ok;
        xfer      = s1_valid & drain_ok;
        xfer_data = s1_data;
      end
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      m_data_d  = xfer_data;
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (state_q != StIdle) begin
      if (xfer) begin
        idle_cnt_d = '0;
        byte_cnt_d = byte_cnt_q + BcW'(1);
        if (xfer_data == TERM || byte_cnt_q == BcW'(MAX_MSG - 1)) begin
          rel = 1'b1;
        end
      end else begin
        if (idle_cnt_q != IcW'(IDLE_TIMEOUT)) begin
          idle_cnt_d = idle_cnt_q + IcW'(1);
        end
        if (idle_cnt_d == IcW'(IDLE_TIMEOUT)) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
      end
      // Release does not wait for the output register to drain.
      if (rel) begin
        state_d    = StIdle;
        rr_d       = (state_q == StLock1);
        byte_cnt_d = '0;
        idle_cnt_d = '0;
      end
    end

    case (state_d)
      StLock0: grant_d = 2'b01;
      StLock1: grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_q       <= 1'b1;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      grant_q    <= 2'b00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-exact vector table, directed corner sequences and a
// randomized run scored against a message-level model of both byte streams.
module tb_uart_tx_arbiter;

  localparam int unsigned MaxMsg = 4;
  localparam int unsigned IdleTo = 16;
  localparam logic [7:0]  Term   = 8'h0A;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s0_data, s1_data, m_data;
  logic       s0_valid, s0_ready, s1_valid, s1_ready, m_valid, m_ready, timeout;
  logic [1:0] grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DATA_W      (8),
    .TERM        (Term),
    .MAX_MSG     (MaxMsg),
    .IDLE_TIMEOUT(IdleTo)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s0_data (s0_data),
    .s0_valid(s0_valid),
    .s0_ready(s0_ready),
    .s1_data (s1_data),
    .s1_valid(s1_valid),
    .s1_ready(s1_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .grant   (grant),
    .timeout (timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  typedef struct {
    bit         rst;
    bit         ck;
    bit         s0v;
    logic [7:0] s0d;
    bit         s1v;
    logic [7:0] s1d;
    bit         mr;
    logic [1:0] g;
    bit         s0r;
    bit         s1r;
    bit         mv;
    logic [7:0] md;
    bit         to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit ck, bit s0v, logic [7:0] s0d, bit s1v,
                             logic [7:0] s1d, bit mr, logic [1:0] g, bit s0r, bit s1r,
                             bit mv, logic [7:0] md, bit to);
    vec_t r;
    r.rst = rst; r.ck = ck; r.s0v = s0v; r.s0d = s0d; r.s1v = s1v; r.s1d = s1d; r.mr = mr;
    r.g = g; r.s0r = s0r; r.s1r = s1r; r.mv = mv; r.md = md; r.to = to;
    return r;
  endfunction

  // Queue-driven sources and the message-level scoreboard.
  logic [7:0] q0[$], q1[$], outq[$];
  logic [8:0] exq[$];
  bit         en0, en1, mr_en, acc0, acc1, obs_to, prev_hold, to_pend;
  logic [1:0] obs_g;
  logic [7:0] hold_data;
  int         cyc, obs_cyc, stall, cur_src, cur_len;

  task automatic sb_clear();
    exq.delete();
    outq.delete();
    prev_hold = 1'b0;
    to_pend   = 1'b0;
    stall     = 0;
    cur_src   = -1;
    cur_len   = 0;
  endtask

  task automatic drive();
    s0_valid = en0 && (q0.size() > 0);
    s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    s1_valid = en1 && (q1.size() > 0);
    s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    m_ready  = mr_en;
  endtask

  task automatic accept(input int src, input logic [7:0] d);
    if (cur_src >= 0) chk("no_interleave", src, cur_src);
    if (cur_src < 0) cur_len = 0;
    exq.push_back({src[0], d});
    cur_src = src;
    cur_len++;
    if (d == Term || cur_len == int'(MaxMsg)) begin
      cur_src = -1;
      cur_len = 0;
    end
  endtask

  task automatic check_cycle();
    logic [8:0] e;
    chk("grant_legal", {31'b0, grant == 2'b11}, 0);
    chk("s0_ready_rule", s0_ready, grant[0] & (~m_valid | m_ready));
    chk("s1_ready_rule", s1_ready, grant[1] & (~m_valid | m_ready));
    if (prev_hold) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_data);
    end
    prev_hold = m_valid & ~m_ready;
    hold_data = m_data;
    if (m_valid && m_ready) begin
      outq.push_back(m_data);
      if (exq.size() == 0) begin
        fail("unexpected_byte");
      end else begin
        e = exq.pop_front();
        chk("out_data", m_data, e[7:0]);
      end
    end
    chk("timeout_rule", timeout, to_pend);
    if (to_pend) begin
      cur_src = -1;
      cur_len = 0;
    end
    if (acc0) accept(0, s0_data);
    if (acc1) accept(1, s1_data);
    // Pulse follows the IdleTo-th consecutive locked cycle without a source transfer.
    if (grant != 2'b00 && !acc0 && !acc1) begin
      stall++;
      to_pend = (stall == int'(IdleTo));
      if (to_pend) stall = 0;
    end else begin
      stall   = 0;
      to_pend = 1'b0;
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    acc0    = s0_valid && s0_ready;
    acc1    = s1_valid && s1_ready;
    obs_to  = timeout;
    obs_g   = grant;
    obs_cyc = cyc;
    if (!reset) check_cycle();
    @(posedge clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; mr_en = 1'b1;
    q0.delete(); q1.delete();
    tick();
    tick();
    reset = 1'b0;
    sb_clear();
  endtask

  task automatic refill(input int src);
    int n;
    logic [7:0] b;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == Term) b = 8'h20;
      if (i == n - 1 && $urandom_range(0, 9) < 6) b = Term;
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 40;
      2: return 90;
      default: return 100;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_seq[$];
    logic [7:0] held;
    int p0, p1, pm, t_acc, guard;
    bit seen;

    reset = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 8'h00; s1_data = 8'h00; m_ready = 1'b1;
    en0 = 1'b0; en1 = 1'b0; mr_en = 1'b1; cyc = 0;
    sb_clear();

    // Reset with both valids high, single message, then contention from reset.
    tbl.push_back(v(1, 0, 1, 8'hA5, 1, 8'h5A, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(1, 1, 1, 8'hA5, 1, 8'h5A, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(1, 1, 1, 8'hA5, 1, 8'h5A, 0, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h48, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h48, 0, 8'h00, 1, 2'b01, 1, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h49, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h48, 0));
    tbl.push_back(v(0, 1, 1, 8'h0A, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h49, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 1, 8'h0A, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(1, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h41, 1, 8'h61, 1, 2'b00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h41, 1, 8'h61, 1, 2'b01, 1, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h0A, 1, 8'h61, 1, 2'b01, 1, 0, 1, 8'h41, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 8'h61, 1, 2'b00, 0, 0, 1, 8'h0A, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 8'h61, 1, 2'b10, 0, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 8'h0A, 1, 2'b10, 0, 1, 1, 8'h61, 0));
    tbl.push_back(v(0, 1, 1, 8'h42, 1, 8'h62, 1, 2'b00, 0, 0, 1, 8'h0A, 0));
    tbl.push_back(v(0, 1, 1, 8'h42, 1, 8'h62, 1, 2'b01, 1, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 8'h0A, 1, 8'h62, 1, 2'b01, 1, 0, 1, 8'h42, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 8'h62, 1, 2'b00, 0, 0, 1, 8'h0A, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 8'h62, 1, 2'b10, 0, 1, 0, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 1, 8'h0A, 1, 2'b10, 0, 1, 1, 8'h62, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 1, 8'h0A, 0));
    tbl.push_back(v(0, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      reset = tbl[i].rst;
      s0_valid = tbl[i].s0v; s0_data = tbl[i].s0d;
      s1_valid = tbl[i].s1v; s1_data = tbl[i].s1d;
      m_ready = tbl[i].mr;
      @(negedge clk);
      if (tbl[i].ck) begin
        chk($sformatf("row%0d grant", i), grant, tbl[i].g);
        chk($sformatf("row%0d s0_ready", i), s0_ready, tbl[i].s0r);
        chk($sformatf("row%0d s1_ready", i), s1_ready, tbl[i].s1r);
        chk($sformatf("row%0d m_valid", i), m_valid, tbl[i].mv);
        chk($sformatf("row%0d timeout", i), timeout, tbl[i].to);
        if (tbl[i].mv || tbl[i].rst) chk($sformatf("row%0d m_data", i), m_data, tbl[i].md);
      end
    end
    @(posedge clk);
    #1;

    // Backpressure: stall m for 10 cycles once the first byte sits in the output register.
    do_reset();
    q0 = '{8'h11, 8'h22, 8'h33, 8'h0A};
    en0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = m_valid;
    end
    chk("bp_first_byte", seen, 1);
    mr_en = 1'b0;
    held = m_data;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, held);
      chk("bp_s0_ready", s0_ready, 0);
    end
    mr_en = 1'b1;
    guard = 0;
    while ((q0.size() > 0 || exq.size() > 0) && guard < 30) begin
      tick();
      guard++;
    end
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h0A};
    chk("bp_count", outq.size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size() && k < outq.size(); k++) chk("bp_byte", outq[k], exp_seq[k]);

    // MAX_MSG: s1 owns first, is cut after its 4th byte, s0 goes next, then s1 finishes.
    do_reset();
    q1 = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
    en1 = 1'b1;
    tick();
    tick();
    q0 = '{8'hA1, 8'h0A};
    en0 = 1'b1;
    guard = 0;
    while (outq.size() < 8 && guard < 60) begin
      tick();
      guard++;
    end
    exp_seq = '{8'h81, 8'h82, 8'h83, 8'h84, 8'hA1, 8'h0A, 8'h85, 8'h86};
    chk("max_count", outq.size(), 8);
    for (int k = 0; k < 8 && k < outq.size(); k++) chk("max_byte", outq[k], exp_seq[k]);

    // Timeout: one byte then silence; pulse lands 16 cycles after the accepting edge.
    do_reset();
    q0 = '{8'h55};
    en0 = 1'b1;
    seen = 1'b0;
    t_acc = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (acc0) begin
        seen = 1'b1;
        t_acc = obs_cyc;
      end
    end
    chk("to_accept", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (obs_to) begin
        seen = 1'b1;
        chk("to_delay", obs_cyc - t_acc, 17);
        chk("to_grant", obs_g, 2'b00);
      end
    end
    chk("to_seen", seen, 1);

    // Reset while a byte is held in the output register.
    do_reset();
    mr_en = 1'b0;
    q0 = '{8'h77, 8'h0A};
    en0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = m_valid;
    end
    chk("mr_loaded", seen, 1);
    reset = 1'b1;
    tick();
    chk("mr_m_valid", m_valid, 0);
    chk("mr_grant", grant, 2'b00);
    chk("mr_s0_ready", s0_ready, 0);
    chk("mr_m_data", m_data, 8'h00);
    do_reset();

    // Randomized traffic in segments of varying source and sink activity.
    for (int seg = 0; seg < 40; seg++) begin
      p0 = pick();
      p1 = pick();
      pm = pick();
      for (int k = 0; k < 25; k++) begin
        if (q0.size() == 0) refill(0);
        if (q1.size() == 0) refill(1);
        en0   = ($urandom_range(0, 99) < p0);
        en1   = ($urandom_range(0, 99) < p1);
        mr_en = ($urandom_range(0, 99) < pm);
        tick();
      end
    end
    en0 = 1'b0;
    en1 = 1'b0;
    mr_en = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    chk("drain_empty", exq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
